// File: rtl/i2c_byte_sequencer_if.sv
// Command/response handshake between the I2C register block and the byte sequencer.
interface i2c_byte_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_wdata;
  logic       cmd_nack;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_ack;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_wdata, cmd_nack,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_ack, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_wdata, cmd_nack,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_ack, rsp_err
  );
endinterface

// File: rtl/i2c_byte_sequencer.sv
// Byte-level I2C master: sequences the SCL generator for START/WRITE/READ/STOP
// and owns the open-drain SDA line using the generator's phase strobes.
module i2c_byte_sequencer #(
  parameter int unsigned START_HOLD_CYC = 20000,
  parameter int unsigned STOP_HOLD_CYC  = 20000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  i2c_byte_sequencer_if.slave  bus,
  output logic                 bus_owned,
  output logic                 sclk_enable,
  output logic                 stop_cond,
  input  logic                 mid_low,
  input  logic                 end_low,
  input  logic                 mid_high,
  input  logic                 end_high,
  input  logic                 sda_in,
  output logic                 sda_drive_low
);

  localparam int unsigned BIT_W = 4;

  typedef enum logic [1:0] {
    OP_START = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_STOP  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE, START_HOLD, OWNED, XFER, STOP_LOW, STOP_WAIT, STOP_HOLD
  } state_e;

  state_e             state;
  logic [CNT_W-1:0]   hold_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [7:0]         tx_sh;
  logic [7:0]         rx_sh;
  logic               is_read;
  logic               nack;
  logic               fin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      bit_cnt       <= '0;
      tx_sh         <= '0;
      rx_sh         <= '0;
      is_read       <= 1'b0;
      nack          <= 1'b0;
      fin           <= 1'b0;
      bus.cmd_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_ack   <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus_owned     <= 1'b0;
      sclk_enable   <= 1'b0;
      stop_cond     <= 1'b0;
      sda_drive_low <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      unique case (state)
        // Command intake; illegal ops answer with an error pulse and leave the bus alone.
        IDLE, OWNED: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.cmd_ready <= 1'b0;
            if (state == IDLE) begin
              if (op_e'(bus.cmd_op) == OP_START) begin
                sda_drive_low <= 1'b1;
                hold_cnt      <= '0;
                state         <= START_HOLD;
              end else begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_err   <= 1'b1;
              end
            end else begin
              unique case (op_e'(bus.cmd_op))
                OP_START: begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= 1'b1;
                end
                OP_STOP: begin
                  sclk_enable <= 1'b1;
                  state       <= STOP_LOW;
                end
                default: begin
                  tx_sh       <= bus.cmd_wdata;
                  is_read     <= (op_e'(bus.cmd_op) == OP_READ);
                  nack        <= bus.cmd_nack;
                  bit_cnt     <= '0;
                  fin         <= 1'b0;
                  sclk_enable <= 1'b1;
                  state       <= XFER;
                end
              endcase
            end
          end else begin
            bus.cmd_ready <= 1'b1;
          end
        end

        START_HOLD: begin
          if (!sclk_enable) begin
            if (hold_cnt == CNT_W'(START_HOLD_CYC - 1)) sclk_enable <= 1'b1;
            else                                       hold_cnt    <= hold_cnt + CNT_W'(1);
          end else if (end_low) begin
            sclk_enable   <= 1'b0;
            bus_owned     <= 1'b1;
            bus.rsp_valid <= 1'b1;
            bus.cmd_ready <= 1'b1;
            state         <= OWNED;
          end
        end

        // Nine bit periods; bit_cnt parks at 9 until the trailing low phase ends.
        XFER: begin
          if (fin) begin
            bus.rsp_valid <= 1'b1;
            if (is_read) bus.rsp_rdata <= rx_sh;
            bus.cmd_ready <= 1'b1;
            fin           <= 1'b0;
            state         <= OWNED;
          end else begin
            if (mid_low && !bit_cnt[3]) begin
              if (is_read) begin
                sda_drive_low <= 1'b0;
              end else begin
                sda_drive_low <= ~tx_sh[7];
                tx_sh         <= {tx_sh[6:0], 1'b0};
              end
            end else if (mid_low && bit_cnt == BIT_W'(8)) begin
              sda_drive_low <= is_read ? ~nack : 1'b0;
            end
            if (mid_high && is_read && !bit_cnt[3]) rx_sh <= {rx_sh[6:0], sda_in};
            if (mid_high && !is_read && bit_cnt == BIT_W'(8)) bus.rsp_ack <= ~sda_in;
            if (end_high && bit_cnt != BIT_W'(9)) bit_cnt <= bit_cnt + BIT_W'(1);
            if (end_low && bit_cnt == BIT_W'(9)) begin
              sclk_enable <= 1'b0;
              fin         <= 1'b1;
            end
          end
        end

        STOP_LOW: begin
          if (mid_low) sda_drive_low <= 1'b1;
          if (end_low) begin
            sclk_enable <= 1'b0;
            stop_cond   <= 1'b1;
            hold_cnt    <= '0;
            state       <= STOP_WAIT;
          end
        end

        STOP_WAIT: begin
          if (hold_cnt == CNT_W'(STOP_HOLD_CYC - 1)) begin
            stop_cond <= 1'b0;
            state     <= STOP_HOLD;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end

        STOP_HOLD: begin
          sda_drive_low <= 1'b0;
          bus_owned     <= 1'b0;
          bus.rsp_valid <= 1'b1;
          bus.cmd_ready <= 1'b1;
          state         <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_byte_sequencer.sv
// Directed bench for i2c_byte_sequencer: the bench plays the SCL generator and the slave.
module tb_i2c_byte_sequencer;
  localparam int unsigned HOLD = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic mid_low, end_low, mid_high, end_high, sda_in;
  logic bus_owned, sclk_enable, stop_cond, sda_drive_low;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  i2c_byte_sequencer_if bus ();

  i2c_byte_sequencer #(
    .START_HOLD_CYC(HOLD),
    .STOP_HOLD_CYC (HOLD),
    .CNT_W         (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .bus_owned    (bus_owned),
    .sclk_enable  (sclk_enable),
    .stop_cond    (stop_cond),
    .mid_low      (mid_low),
    .end_low      (end_low),
    .mid_high     (mid_high),
    .end_high     (end_high),
    .sda_in       (sda_in),
    .sda_drive_low(sda_drive_low)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // {cmd_ready, rsp_valid, rsp_err, rsp_ack, bus_owned, sclk_enable, stop_cond, sda_drive_low}
  function automatic logic [7:0] st();
    return {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_ack,
            bus_owned, sclk_enable, stop_cond, sda_drive_low};
  endfunction

  task automatic pulse(input int unsigned which);
    case (which)
      0:       mid_low  = 1'b1;
      1:       end_low  = 1'b1;
      2:       mid_high = 1'b1;
      default: end_high = 1'b1;
    endcase
    tick;
    mid_low = 1'b0; end_low = 1'b0; mid_high = 1'b0; end_high = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] d, input logic n);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_wdata = d;
    bus.cmd_nack  = n;
    tick;
    bus.cmd_valid = 1'b0;
  endtask

  // START through parking SCL low; returns cycles until sclk_enable rose.
  task automatic do_start(input string tag);
    int n;
    chk({tag, "_ready"}, 32'(bus.cmd_ready), 1);
    send(2'b00, 8'h00, 1'b0);
    chk({tag, "_sda_low"}, 32'({sclk_enable, sda_drive_low}), 32'h1);
    n = 0;
    while (!sclk_enable && n < 20) begin
      tick;
      n++;
    end
    chk({tag, "_hold_cycles"}, 32'(n), HOLD);
    pulse(1);
    chk({tag, "_owned"}, 32'(st() & 8'hEF), 32'hC9 & 32'hEF);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wd;
    logic [7:0] rd;
    int n;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_wdata = 8'h00; bus.cmd_nack = 1'b0;
    mid_low = 1'b0; end_low = 1'b0; mid_high = 1'b0; end_high = 1'b0; sda_in = 1'b1;
    tick; tick;
    chk("reset_state", 32'(st()), 32'h80);
    chk("reset_rdata", 32'(bus.rsp_rdata), 0);
    rst_n = 1'b1;
    tick;

    // Illegal WRITE in IDLE
    send(2'b01, 8'h55, 1'b0);
    chk("illegal_write_idle", 32'(st()), 32'h60);
    tick;
    chk("illegal_write_recover", 32'(st()), 32'h80);

    do_start("start1");
    chk("start1_noerr", 32'(bus.rsp_err), 0);

    // Illegal START while owning the bus
    send(2'b00, 8'h00, 1'b0);
    chk("illegal_start_owned", 32'(st()), 32'h69);
    tick;

    // WRITE 0xA5, slave ACKs in bit 8
    wd = 8'hA5;
    send(2'b01, wd, 1'b0);
    chk("wr_accept", 32'({bus.cmd_ready, sclk_enable}), 32'h1);
    for (int i = 0; i < 9; i++) begin
      pulse(0);
      if (i < 8) chk($sformatf("wr_bit%0d", i), 32'(!sda_drive_low), 32'(wd[7-i]));
      else       chk("wr_ack_release", 32'(sda_drive_low), 0);
      pulse(1);
      sda_in = (i == 8) ? 1'b0 : !sda_drive_low;
      pulse(2);
      pulse(3);
      sda_in = 1'b1;
    end
    pulse(0);
    chk("wr_tail_sda", 32'(sda_drive_low), 0);
    pulse(1);
    chk("wr_10th_end_low", 32'({bus.rsp_valid, sclk_enable}), 0);
    tick;
    chk("wr_done", 32'(st()), 32'hD8);

    // READ with NACK, slave returns 0x3C
    rd = 8'h3C;
    send(2'b10, 8'h00, 1'b1);
    chk("rd_accept", 32'(sclk_enable), 1);
    for (int i = 0; i < 9; i++) begin
      pulse(0);
      chk($sformatf("rd_sda_rel%0d", i), 32'(sda_drive_low), 0);
      pulse(1);
      sda_in = (i < 8) ? rd[7-i] : !sda_drive_low;
      pulse(2);
      pulse(3);
      sda_in = 1'b1;
    end
    pulse(0);
    pulse(1);
    chk("rd_rdata_held", 32'({bus.rsp_valid, bus.rsp_rdata}), 0);
    tick;
    chk("rd_done", 32'(st()), 32'hD8);
    chk("rd_rdata", 32'(bus.rsp_rdata), 32'h3C);

    // STOP
    send(2'b11, 8'h00, 1'b0);
    chk("stop_accept", 32'({sclk_enable, sda_drive_low}), 32'h2);
    pulse(0);
    chk("stop_sda_low", 32'(sda_drive_low), 1);
    pulse(1);
    chk("stop_cond_set", 32'({sclk_enable, stop_cond}), 32'h1);
    n = 1;
    while (stop_cond && n < 50) begin
      tick;
      if (stop_cond) n++;
    end
    chk("stop_cond_cycles", 32'(n), HOLD);
    chk("stop_sda_still_low", 32'({bus_owned, sda_drive_low}), 32'h3);
    tick;
    chk("stop_done", 32'(st()), 32'hD0);

    // Reset during bit 4 of a WRITE 0x00
    do_start("start2");
    send(2'b01, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pulse(0); pulse(1);
      sda_in = !sda_drive_low;
      pulse(2); pulse(3);
      sda_in = 1'b1;
    end
    pulse(0);
    chk("bit4_driving", 32'({sclk_enable, sda_drive_low}), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_state", 32'(st()), 32'h80);
    tick;
    rst_n = 1'b1;
    tick;
    do_start("start3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
